// File: rtl/layer_seq_pkg.sv
// Shared types for the layer sequencer: FSM state encoding and the error
// vector bit positions used by the top and by anything decoding err flags.
package layer_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_SPURIOUS = 1;
    localparam int ERR_OVERRUN  = 2;
    localparam int ERR_W        = 3;

endpackage

// File: rtl/seq_watchdog.sv
// Per-layer watchdog: clearable up-counter that flags expiry on the last
// cycle a running layer may still report done. TIMEOUT=0 removes it.
module seq_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int CW = $clog2(TIMEOUT + 1);
            // Count is 0 in the start-pulse cycle, so the last accepting
            // cycle holds TIMEOUT-1; expiry there makes the abort visible at
            // start + TIMEOUT once registered.
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (en_i && (cnt_q != LAST)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expire_o = en_i && (cnt_q == LAST);
        end else begin : g_off
            logic unused_wd;
            assign unused_wd = ^{clk, rst_n, clr_i, en_i};
            assign expire_o  = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/layer_seq_ctrl.sv
// Frame sequencer: launches N_LAYERS layers in order with a fixed hand-off
// gap, guards each layer with a watchdog and records protocol errors.
module layer_seq_ctrl
    import layer_seq_pkg::*;
#(
    parameter int N_LAYERS    = 4,
    parameter int HANDOFF_DLY = 2,
    parameter int TIMEOUT     = 1023,
    parameter int LW          = $clog2(N_LAYERS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start_i,
    input  logic [N_LAYERS-1:0] layer_done_i,
    input  logic                clear_err_i,
    output logic [N_LAYERS-1:0] layer_start_o,
    output logic                busy_o,
    output logic [LW-1:0]       active_layer_o,
    output logic                frame_done_o,
    output logic                err_timeout_o,
    output logic                err_spurious_o,
    output logic                err_overrun_o
);

    localparam int GW = $clog2(HANDOFF_DLY + 1);
    localparam logic [LW-1:0] LAST_IDX = LW'(N_LAYERS - 1);

    state_e              state_q, state_d;
    logic [LW-1:0]       idx_q, idx_d;
    logic [LW-1:0]       act_q, act_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [N_LAYERS-1:0] start_q, start_d;
    logic [N_LAYERS-1:0] idx_oh;
    logic                busy_q, busy_d;
    logic                fdone_q, fdone_d;
    logic [ERR_W-1:0]    err_q, err_d, err_new;
    logic                launch;
    logic                done_hit;
    logic                wd_expire;

    assign idx_oh   = N_LAYERS'(1) << idx_q;
    assign done_hit = |(layer_done_i & idx_oh);

    seq_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (launch),
        .en_i    (state_q == RUN),
        .expire_o(wd_expire)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        start_d = '0;
        fdone_d = 1'b0;
        launch  = 1'b0;
        err_new = '0;

        case (state_q)
            IDLE: begin
                err_new[ERR_SPURIOUS] = |layer_done_i;
                if (frame_start_i) begin
                    state_d    = RUN;
                    idx_d      = '0;
                    launch     = 1'b1;
                    start_d[0] = 1'b1;
                end
            end
            RUN: begin
                err_new[ERR_SPURIOUS] = |(layer_done_i & ~idx_oh);
                // A done in the expiry cycle still counts: check done first.
                if (done_hit) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        fdone_d = 1'b1;
                    end else begin
                        idx_d = idx_q + LW'(1);
                        if (HANDOFF_DLY == 1) begin
                            launch  = 1'b1;
                            start_d = idx_oh << 1;
                        end else begin
                            state_d = GAP;
                            gap_d   = GW'(HANDOFF_DLY - 1);
                        end
                    end
                end else if (wd_expire) begin
                    state_d              = IDLE;
                    err_new[ERR_TIMEOUT] = 1'b1;
                end
            end
            GAP: begin
                err_new[ERR_SPURIOUS] = |layer_done_i;
                if (gap_q == GW'(1)) begin
                    state_d = RUN;
                    launch  = 1'b1;
                    start_d = idx_oh;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        err_new[ERR_OVERRUN] = frame_start_i && (state_q != IDLE);
    end

    assign busy_d = (state_d != IDLE);
    assign act_d  = busy_d ? idx_d : '0;
    // New errors override a coincident clear.
    assign err_d  = (err_q & ~{ERR_W{clear_err_i}}) | err_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            start_q <= '0;
            fdone_q <= 1'b0;
            busy_q  <= 1'b0;
            act_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            start_q <= start_d;
            fdone_q <= fdone_d;
            busy_q  <= busy_d;
            act_q   <= act_d;
            err_q   <= err_d;
        end
    end

    assign layer_start_o  = start_q;
    assign busy_o         = busy_q;
    assign active_layer_o = act_q;
    assign frame_done_o   = fdone_q;
    assign err_timeout_o  = err_q[ERR_TIMEOUT];
    assign err_spurious_o = err_q[ERR_SPURIOUS];
    assign err_overrun_o  = err_q[ERR_OVERRUN];

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Scoreboard bench: frame plans are turned into an input schedule plus
// expected pulse/status records; a negedge monitor compares against them.
module tb_layer_seq_ctrl;

    localparam int N_L = 4;
    localparam int DLY = 2;
    localparam int TO  = 15;
    localparam int LW  = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic fs0 = 1'b0, clr0 = 1'b0, fs1 = 1'b0, clr1 = 1'b0;
    logic [N_L-1:0] ld0 = '0, ld1 = '0, ls0, ls1;
    logic busy0, fd0, eto0, esp0, eov0;
    logic busy1, fd1, eto1, esp1, eov1;
    logic [LW-1:0] act0, act1;

    int cyc = 0, n_chk = 0, n_fail = 0, end_c = 32'h3fff_ffff;

    typedef struct {
        int cyc; int which; logic [N_L-1:0] ls; logic fd;
    } ev_t;
    typedef struct {
        int cyc; logic busy; logic [LW-1:0] act; logic [2:0] err; logic care; string name;
    } chk_t;

    ev_t  exp_q[$];
    chk_t chk_q[$];
    logic [N_L-1:0] sd0[int], sd1[int];
    bit sfs0[int], sfs1[int], sclr[int], srst[int];

    layer_seq_ctrl #(.N_LAYERS(N_L), .HANDOFF_DLY(DLY), .TIMEOUT(TO), .LW(LW)) u_dut (
        .clk(clk), .rst_n(rst_n), .frame_start_i(fs0), .layer_done_i(ld0),
        .clear_err_i(clr0), .layer_start_o(ls0), .busy_o(busy0),
        .active_layer_o(act0), .frame_done_o(fd0), .err_timeout_o(eto0),
        .err_spurious_o(esp0), .err_overrun_o(eov0));

    layer_seq_ctrl #(.N_LAYERS(N_L), .HANDOFF_DLY(1), .TIMEOUT(TO), .LW(LW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .frame_start_i(fs1), .layer_done_i(ld1),
        .clear_err_i(clr1), .layer_start_o(ls1), .busy_o(busy1),
        .active_layer_o(act1), .frame_done_o(fd1), .err_timeout_o(eto1),
        .err_spurious_o(esp1), .err_overrun_o(eov1));

    always #5 clk = ~clk;

    // Plays the precomputed schedule; inputs change 1 time unit after the edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        rst_n = (cyc > 3);
        fs0   = (sfs0.exists(cyc) != 0);
        fs1   = (sfs1.exists(cyc) != 0);
        ld0   = (sd0.exists(cyc) != 0) ? sd0[cyc] : '0;
        ld1   = (sd1.exists(cyc) != 0) ? sd1[cyc] : '0;
        clr0  = (sclr.exists(cyc) != 0);
        clr1  = 1'b0;
        if (srst.exists(cyc) != 0) begin
            #2;
            rst_n = 1'b0;
        end
    end

    function automatic void push_ev(input int w, input int c, input logic [N_L-1:0] ls, input logic fd);
        ev_t e;
        e.cyc = c; e.which = w; e.ls = ls; e.fd = fd;
        exp_q.push_back(e);
    endfunction

    function automatic void push_chk(input int c, input logic b, input logic [LW-1:0] a,
                                     input logic [2:0] e, input logic care, input string nm);
        chk_t k;
        k.cyc = c; k.busy = b; k.act = a; k.err = e; k.care = care; k.name = nm;
        chk_q.push_back(k);
    endfunction

    function automatic void add_done(input int w, input int c, input int k);
        logic [N_L-1:0] v;
        v = N_L'(1) << k;
        if (w == 0) sd0[c] = (sd0.exists(c) != 0) ? (sd0[c] | v) : v;
        else        sd1[c] = (sd1.exists(c) != 0) ? (sd1[c] | v) : v;
    endfunction

    // Reference model: a layer started in s and answering after lat cycles is
    // done in s+lat; the next one starts dly cycles later; lat >= TO aborts at s+TO.
    function automatic void plan_frame(input int w, input int f, input int lat[N_L],
                                       input logic [2:0] errv, input logic care, output int fin);
        int s, d, dly;
        bit alive;
        dly = (w == 0) ? DLY : 1;
        if (w == 0) sfs0[f] = 1'b1; else sfs1[f] = 1'b1;
        s = f + 1; alive = 1'b1; fin = s;
        for (int k = 0; k < N_L; k++) begin
            if (alive) begin
                push_ev(w, s, N_L'(1) << k, 1'b0);
                if (w == 0) push_chk(s, 1'b1, LW'(k), errv, care, "layer_run");
                if (lat[k] >= TO) begin
                    if (w == 0) begin
                        push_chk(s + TO - 1, 1'b1, LW'(k), errv, care, "pre_timeout");
                        push_chk(s + TO, 1'b0, '0, errv | 3'b001, care, "timeout");
                    end
                    fin = s + TO; alive = 1'b0;
                end else begin
                    d = s + lat[k];
                    add_done(w, d, k);
                    if (k == N_L - 1) begin
                        push_ev(w, d + 1, '0, 1'b1);
                        if (w == 0) push_chk(d + 1, 1'b0, '0, errv, care, "frame_end");
                        fin = d + 1;
                    end else begin
                        if (w == 0) push_chk(d + 1, 1'b1, LW'(k + 1), errv, care, "handoff");
                        s = d + dly;
                    end
                end
            end
        end
    endfunction

    ev_t m_e;
    logic [N_L-1:0] m_ls;
    logic m_fd;

    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) begin
            m_ls = (w == 0) ? ls0 : ls1;
            m_fd = (w == 0) ? fd0 : fd1;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_chk++; n_fail++;
                $display("FAIL missed_pulse: dut%0d saw nothing, required ls=%b fd=%b at cycle %0d",
                         exp_q[0].which, exp_q[0].ls, exp_q[0].fd, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (m_ls != '0 || m_fd) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: dut%0d ls=%b fd=%b at cycle %0d, required none", w, m_ls, m_fd, cyc);
                end else begin
                    m_e = exp_q.pop_front();
                    if (m_e.cyc != cyc || m_e.which != w || m_e.ls != m_ls || m_e.fd != m_fd) begin
                        n_fail++;
                        $display("FAIL pulse: dut%0d ls=%b fd=%b at cycle %0d, required dut%0d ls=%b fd=%b at cycle %0d",
                                 w, m_ls, m_fd, cyc, m_e.which, m_e.ls, m_e.fd, m_e.cyc);
                    end
                end
            end
        end
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].cyc == cyc) begin
                n_chk++;
                if (busy0 !== chk_q[i].busy || act0 !== chk_q[i].act ||
                    (chk_q[i].care && {eov0, esp0, eto0} !== chk_q[i].err)) begin
                    n_fail++;
                    $display("FAIL %s @%0d: busy=%b act=%0d err=%b, required busy=%b act=%0d err=%b",
                             chk_q[i].name, cyc, busy0, act0, {eov0, esp0, eto0},
                             chk_q[i].busy, chk_q[i].act, chk_q[i].err);
                end
                chk_q.delete(i);
            end
        end
        if (cyc == end_c) begin
            n_chk++;
            if (exp_q.size() != 0 || chk_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover: %0d pulses and %0d status checks pending, required 0 and 0",
                         exp_q.size(), chk_q.size());
            end
            n_chk++;
            if ({busy1, act1, eov1, esp1, eto1} !== '0) begin
                n_fail++;
                $display("FAIL dly1_final: busy=%b act=%0d err=%b, required all 0",
                         busy1, act1, {eov1, esp1, eto1});
            end
        end
    end

    initial begin
        int f, fin, x, y, d0;
        int lat[N_L];
        bit tmo;

        push_chk(2, 1'b0, '0, 3'b000, 1'b1, "reset_state");

        // Nominal frame: starts 11/18/25/32, frame_done 38.
        lat = '{5, 5, 5, 5};
        plan_frame(0, 10, lat, 3'b000, 1'b1, fin);
        push_chk(38, 1'b0, '0, 3'b000, 1'b1, "nominal_done_38");

        // Back-to-back start in the frame_done cycle; every done lands on expiry.
        lat = '{TO - 1, TO - 1, TO - 1, TO - 1};
        plan_frame(0, fin, lat, 3'b000, 1'b1, fin);

        // Layer 2 never answers.
        lat = '{5, 5, TO, 5};
        plan_frame(0, fin + 3, lat, 3'b000, 1'b1, fin);
        sclr[fin + 1] = 1'b1;
        push_chk(fin + 1, 1'b0, '0, 3'b001, 1'b1, "timeout_sticky");
        push_chk(fin + 2, 1'b0, '0, 3'b000, 1'b1, "timeout_cleared");

        // Spurious done and overrun while layer 1 runs.
        f = fin + 4;
        lat = '{6, 6, 6, 6};
        plan_frame(0, f, lat, 3'b000, 1'b0, fin);
        x = f + 10;
        add_done(0, x, 3);
        sfs0[x] = 1'b1;
        push_chk(x, 1'b1, LW'(1), 3'b000, 1'b1, "pre_errors");
        push_chk(x + 1, 1'b1, LW'(1), 3'b110, 1'b1, "spurious_overrun");
        sclr[fin + 2] = 1'b1;
        push_chk(fin + 2, 1'b0, '0, 3'b110, 1'b1, "errors_held");
        push_chk(fin + 3, 1'b0, '0, 3'b000, 1'b1, "errors_cleared");

        // clear_err together with a fresh spurious done keeps the flag.
        y = fin + 5;
        add_done(0, y, 2);
        push_chk(y + 1, 1'b0, '0, 3'b010, 1'b1, "idle_spurious");
        add_done(0, y + 3, 1);
        sclr[y + 3] = 1'b1;
        push_chk(y + 4, 1'b0, '0, 3'b010, 1'b1, "clear_vs_new");
        sclr[y + 6] = 1'b1;
        push_chk(y + 7, 1'b0, '0, 3'b000, 1'b1, "clear_after");

        // Reset asserted during the gap after layer 0.
        f = y + 10;
        sfs0[f] = 1'b1;
        push_ev(0, f + 1, N_L'(1), 1'b0);
        d0 = f + 4;
        add_done(0, d0, 0);
        push_chk(d0, 1'b1, '0, 3'b000, 1'b1, "pre_reset");
        srst[d0 + 1] = 1'b1;
        push_chk(d0 + 1, 1'b0, '0, 3'b000, 1'b1, "reset_mid_gap");
        push_chk(d0 + 4, 1'b0, '0, 3'b000, 1'b1, "after_reset");
        fin = d0 + 10;

        // Randomized frames, some with a silent layer.
        for (int n = 0; n < 10; n++) begin
            f = fin + ((n == 0) ? 0 : int'($urandom_range(0, 3)));
            for (int k = 0; k < N_L; k++) lat[k] = int'($urandom_range(0, TO - 1));
            tmo = ($urandom_range(0, 2) == 0);
            if (tmo) lat[$urandom_range(0, N_L - 1)] = TO;
            plan_frame(0, f, lat, 3'b000, 1'b1, fin);
            if (tmo) begin
                sclr[fin + 1] = 1'b1;
                push_chk(fin + 1, 1'b0, '0, 3'b001, 1'b1, "rand_timeout_sticky");
                fin = fin + 2;
            end
        end

        // Single-cycle hand-off build.
        lat = '{3, 0, TO - 1, 2};
        plan_frame(1, fin + 5, lat, 3'b000, 1'b1, fin);
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < N_L; k++) lat[k] = int'($urandom_range(0, 8));
            plan_frame(1, fin + int'($urandom_range(0, 2)), lat, 3'b000, 1'b1, fin);
        end

        end_c = fin + 20;
        while (cyc <= end_c + 1) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
